// File: rtl/pht_update_scheduler_pkg.sv
// Shared fetch-unit types for gshare PHT training.
// Holds the commit-side branch result and the queued PHT write format.
package pht_update_scheduler_pkg;

   localparam int INSN_ADDR_BIT_WIDTH = 2;
   localparam int PC_WIDTH = 32;
   localparam int PHT_IDX_W = 10;
   localparam int PHT_ENTRY_WIDTH = 2;
   localparam int BRANCH_GLOBAL_HISTORY_BIT_SIZE = 10;
   localparam int PHT_QUEUE_SIZE = 32;
   localparam int PHT_QUEUE_SIZE_BIT_WIDTH = $clog2(PHT_QUEUE_SIZE);
   localparam int PHT_UPDATE_DROP_COUNT_WIDTH = 16;

   typedef logic [PC_WIDTH-1:0] PC_Path;
   typedef logic [BRANCH_GLOBAL_HISTORY_BIT_SIZE-1:0] BranchGlobalHistoryPath;
   typedef logic [PHT_IDX_W-1:0] PHT_IndexPath;
   typedef logic [PHT_ENTRY_WIDTH-1:0] PHT_EntryPath;
   typedef logic [PHT_QUEUE_SIZE_BIT_WIDTH:0] PhtQueuePointerPath;

   localparam PHT_EntryPath PHT_ENTRY_MAX = '1;

   typedef struct packed {
      logic                   valid;
      logic                   isCondBr;
      logic                   isAX;
      PC_Path                 brAddr;
      BranchGlobalHistoryPath globalHistory;
      PHT_EntryPath           phtPrevValue;
      logic                   execTaken;
   } BranchResult;

   typedef struct packed {
      PHT_IndexPath idx;
      PHT_EntryPath val;
   } PhtUpdateEntry;

   function automatic PHT_IndexPath ToPHT_Index(
      input PC_Path                 addr,
      input BranchGlobalHistoryPath ghr
   );
      return addr[PHT_IDX_W+INSN_ADDR_BIT_WIDTH-1:INSN_ADDR_BIT_WIDTH]
             ^ PHT_IndexPath'(ghr);
   endfunction

   function automatic PHT_EntryPath SaturateCounter(
      input PHT_EntryPath v,
      input logic         taken
   );
      if (taken)
         return (v == PHT_ENTRY_MAX) ? v : v + PHT_EntryPath'(1);
      else
         return (v == '0) ? v : v - PHT_EntryPath'(1);
   endfunction

endpackage

// File: rtl/pht_update_if.sv
// Commit-lane results in, single PHT write port and status out.
// master drives branch results and busy; slave is the scheduler.
interface pht_update_if #(
   parameter int REQ_NUM = 2
) ();
   import pht_update_scheduler_pkg::*;

   BranchResult  brResult [REQ_NUM];
   logic         phtWrBusy;
   logic         phtWE;
   PHT_IndexPath phtWA;
   PHT_EntryPath phtWV;
   logic         stallReq;
   logic [PHT_UPDATE_DROP_COUNT_WIDTH-1:0] dropCount;

   modport master (
      output brResult,
      output phtWrBusy,
      input  phtWE,
      input  phtWA,
      input  phtWV,
      input  stallReq,
      input  dropCount
   );

   modport slave (
      input  brResult,
      input  phtWrBusy,
      output phtWE,
      output phtWA,
      output phtWV,
      output stallReq,
      output dropCount
   );

endinterface

// File: rtl/pht_update_scheduler_queue.sv
// Multi-push / single-pop circular buffer of PHT updates.
// The newest entry can have its value rewritten in place (coalescing).
module pht_update_queue
   import pht_update_scheduler_pkg::*;
#(
   parameter int REQ_NUM    = 2,
   parameter int QUEUE_SIZE = PHT_QUEUE_SIZE,
   localparam int IDX_W     = $clog2(QUEUE_SIZE),
   localparam int PTR_W     = IDX_W + 1,
   localparam int NUM_W     = $clog2(REQ_NUM + 1)
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             flush,
   input  logic [NUM_W-1:0] push_num,
   input  PhtUpdateEntry    push_data [REQ_NUM],
   input  logic             ovr_en,
   input  PHT_EntryPath     ovr_val,
   input  logic             pop,
   output PhtUpdateEntry    head_data,
   output PhtUpdateEntry    tail_data,
   output logic [PTR_W-1:0] count
);

   typedef logic [PTR_W-1:0] ptr_t;

   PhtUpdateEntry    mem_q [QUEUE_SIZE];
   PhtUpdateEntry    mem_d [QUEUE_SIZE];
   ptr_t             head_q, head_d;
   ptr_t             tail_q, tail_d;
   logic [IDX_W-1:0] tail_slot;

   assign tail_slot = IDX_W'(tail_q - ptr_t'(1));
   assign count     = tail_q - head_q;
   assign head_data = mem_q[head_q[IDX_W-1:0]];
   assign tail_data = mem_q[tail_slot];

   always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
      end else begin
         if (ovr_en)
            mem_d[tail_slot].val = ovr_val;
         for (int i = 0; i < REQ_NUM; i++) begin
            if (i < int'(push_num))
               mem_d[tail_q[IDX_W-1:0] + IDX_W'(i)] = push_data[i];
         end
         tail_d = tail_q + ptr_t'(push_num);
         if (pop)
            head_d = head_q + ptr_t'(1);
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         head_q <= '0;
         tail_q <= '0;
         for (int i = 0; i < QUEUE_SIZE; i++)
            mem_q[i] <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         mem_q  <= mem_d;
      end
   end

endmodule

// File: rtl/pht_update_scheduler.sv
// Gathers commit-lane branch results into PHT counter updates and
// drains them one per cycle into the PHT write port.
module pht_update_scheduler
   import pht_update_scheduler_pkg::*;
#(
   parameter int REQ_NUM      = 2,
   parameter int QUEUE_SIZE   = PHT_QUEUE_SIZE,
   parameter int STALL_MARGIN = 2,
   localparam int CNT_W       = $clog2(QUEUE_SIZE) + 1,
   localparam int NUM_W       = $clog2(REQ_NUM + 1),
   localparam int DCW         = PHT_UPDATE_DROP_COUNT_WIDTH
) (
   input logic         clk,
   input logic         rstN,
   input logic         flush,
   pht_update_if.slave io
);

   PhtUpdateEntry    push_data [REQ_NUM];
   PhtUpdateEntry    head_data, tail_data;
   logic [CNT_W-1:0] count;
   logic [NUM_W-1:0] push_num;
   logic             ovr_en;
   PHT_EntryPath     ovr_val;
   logic             pop;
   logic             tail_mergeable;
   int               n_alloc, n_drop, free_slots, count_next;

   logic             phtWE_q, phtWE_d;
   PHT_IndexPath     phtWA_q, phtWA_d;
   PHT_EntryPath     phtWV_q, phtWV_d;
   logic             stallReq_q, stallReq_d;
   logic [DCW-1:0]   dropCount_q, dropCount_d;
   logic [DCW:0]     drop_sum;

   assign pop = !flush && (count != '0) && !io.phtWrBusy;
   assign free_slots = QUEUE_SIZE - int'(count) + int'(pop);

   // The entry leaving this cycle must keep the value it was queued with.
   assign tail_mergeable = (count != '0) && !(pop && count == CNT_W'(1));

   always_comb begin
      for (int i = 0; i < REQ_NUM; i++)
         push_data[i] = '0;
      n_alloc = 0;
      n_drop  = 0;
      ovr_en  = 1'b0;
      ovr_val = tail_data.val;
      for (int l = 0; l < REQ_NUM; l++) begin
         logic         lane_en;
         logic         hit;
         PHT_IndexPath idx;
         PHT_EntryPath val;
         lane_en = !flush && io.brResult[l].valid
                   && io.brResult[l].isCondBr && !io.brResult[l].isAX;
         idx = ToPHT_Index(io.brResult[l].brAddr,
                           io.brResult[l].globalHistory);
         val = SaturateCounter(io.brResult[l].phtPrevValue,
                               io.brResult[l].execTaken);
         hit = 1'b0;
         if (lane_en) begin
            for (int j = 0; j < REQ_NUM; j++) begin
               if (j < n_alloc && push_data[j].idx == idx) begin
                  push_data[j].val = val;
                  hit = 1'b1;
               end
            end
            if (!hit && tail_mergeable && tail_data.idx == idx) begin
               ovr_en  = 1'b1;
               ovr_val = val;
               hit     = 1'b1;
            end
            if (!hit) begin
               if (n_alloc < free_slots) begin
                  push_data[n_alloc].idx = idx;
                  push_data[n_alloc].val = val;
                  n_alloc++;
               end else begin
                  n_drop++;
               end
            end
         end
      end
      push_num = NUM_W'(n_alloc);
   end

   pht_update_queue #(
      .REQ_NUM    (REQ_NUM),
      .QUEUE_SIZE (QUEUE_SIZE)
   ) u_queue (
      .clk       (clk),
      .rstN      (rstN),
      .flush     (flush),
      .push_num  (push_num),
      .push_data (push_data),
      .ovr_en    (ovr_en),
      .ovr_val   (ovr_val),
      .pop       (pop),
      .head_data (head_data),
      .tail_data (tail_data),
      .count     (count)
   );

   assign count_next = int'(count) + n_alloc - int'(pop);
   assign drop_sum   = {1'b0, dropCount_q} + (DCW+1)'(n_drop);

   always_comb begin
      phtWE_d     = pop;
      phtWA_d     = pop ? head_data.idx : phtWA_q;
      phtWV_d     = pop ? head_data.val : phtWV_q;
      stallReq_d  = !flush && (count_next > QUEUE_SIZE - STALL_MARGIN);
      dropCount_d = drop_sum[DCW] ? '1 : drop_sum[DCW-1:0];
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         phtWE_q     <= 1'b0;
         phtWA_q     <= '0;
         phtWV_q     <= '0;
         stallReq_q  <= 1'b0;
         dropCount_q <= '0;
      end else begin
         phtWE_q     <= phtWE_d;
         phtWA_q     <= phtWA_d;
         phtWV_q     <= phtWV_d;
         stallReq_q  <= stallReq_d;
         dropCount_q <= dropCount_d;
      end
   end

   assign io.phtWE     = phtWE_q;
   assign io.phtWA     = phtWA_q;
   assign io.phtWV     = phtWV_q;
   assign io.stallReq  = stallReq_q;
   assign io.dropCount = dropCount_q;

endmodule
